// File: rtl/sqrt_seq_ctrl.sv
// sqrt_seq_ctrl: control layer of a sequential integer square-root unit.
// It computes floor(sqrt(X)) and X - root^2 by subtracting successive odd
// numbers from the radicand. All arithmetic goes through one external
// combinational 16-bit CLA, which is time-shared between the subtract step
// (A + ~B + 1) and the odd-number increment step (A + 2).
module sqrt_seq_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] x_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  root_o,
    output logic [15:0] rem_o,
    output logic [15:0] add_a_o,
    output logic [15:0] add_b_o,
    output logic        add_ci_o,
    input  logic [15:0] add_s_i,
    input  logic        add_co_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        INC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] rem_r;       // running remainder
    logic [15:0] odd_r;       // current odd number, peaks at 511
    logic [7:0]  root_r;      // result root, held until the next DONE
    logic [15:0] rem_out_r;   // result remainder, held until the next DONE

    // State register with synchronous reset; reset discards any computation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: the CLA carry-out alone decides when the loop ends.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_nxt_s = SUB;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SUB: begin
                if (add_co_i) begin
                    state_nxt_s = INC;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            INC:     state_nxt_s = SUB;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath registers: capture radicand, accept CLA results, latch the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_r     <= 16'd0;
            odd_r     <= 16'd0;
            root_r    <= 8'd0;
            rem_out_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        rem_r <= x_i;
                        odd_r <= 16'd1;
                    end else begin
                        rem_r <= rem_r;
                        odd_r <= odd_r;
                    end
                end
                SUB: begin
                    if (add_co_i) begin
                        // No borrow: the subtraction result becomes the new remainder.
                        rem_r <= add_s_i;
                    end else begin
                        // Borrow: the failing subtraction is dropped; root = (odd-1)/2.
                        root_r    <= odd_r[8:1];
                        rem_out_r <= rem_r;
                    end
                end
                INC: begin
                    odd_r <= add_s_i;
                end
                DONE: begin
                    rem_r <= rem_r;
                end
                default: begin
                    rem_r <= rem_r;
                end
            endcase
        end
    end

    // Output decode: status flags and CLA operand steering from the current state.
    always_comb begin
        busy_o   = 1'b0;
        done_o   = 1'b0;
        add_a_o  = 16'd0;
        add_b_o  = 16'd0;
        add_ci_o = 1'b0;
        case (state_r)
            IDLE: begin
                busy_o = 1'b0;
            end
            SUB: begin
                busy_o   = 1'b1;
                add_a_o  = rem_r;
                add_b_o  = ~odd_r;
                add_ci_o = 1'b1;
            end
            INC: begin
                busy_o   = 1'b1;
                add_a_o  = odd_r;
                add_b_o  = 16'h0002;
                add_ci_o = 1'b0;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign root_o = root_r;
    assign rem_o  = rem_out_r;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Self-checking bench for sqrt_seq_ctrl with a behavioural CLA and a
// plain-arithmetic reference model of the odd-subtraction square root.
module tb_sqrt_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] x_i;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  root_o;
    logic [15:0] rem_o;
    logic [15:0] add_a_o;
    logic [15:0] add_b_o;
    logic        add_ci_o;
    logic [15:0] add_s_i;
    logic        add_co_i;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    // Behavioural 16-bit adder standing in for the external CLA.
    assign {add_co_i, add_s_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + {16'd0, add_ci_o};

    sqrt_seq_ctrl dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .x_i      (x_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .root_o   (root_o),
        .rem_o    (rem_o),
        .add_a_o  (add_a_o),
        .add_b_o  (add_b_o),
        .add_ci_o (add_ci_o),
        .add_s_i  (add_s_i),
        .add_co_i (add_co_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int ref_root(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // One operation: start at a negedge, follow every busy cycle, check result.
    // inject_cyc > 0 pulses start_i with another radicand in that busy cycle.
    task automatic do_op(input int x, input int inject_cyc);
        int r;
        int rem;
        int c;
        int k;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        r   = ref_root(x);
        rem = x - r * r;
        @(negedge clk_i);
        start_i = 1'b1;
        x_i     = 16'(x);
        @(negedge clk_i);
        start_i = 1'b0;
        x_i     = 16'($urandom);
        c = 1;
        while (!done_o && c < 600) begin
            if (c % 2 == 1) begin
                k     = (c - 1) / 2;
                exp_a = 16'(x - k * k);
                exp_b = ~16'(2 * k + 1);
                check("sub_a", {16'd0, add_a_o}, {16'd0, exp_a});
                check("sub_b", {16'd0, add_b_o}, {16'd0, exp_b});
                check("sub_ci", {31'd0, add_ci_o}, 32'd1);
            end else begin
                k     = c / 2 - 1;
                exp_a = 16'(2 * k + 1);
                check("inc_a", {16'd0, add_a_o}, {16'd0, exp_a});
                check("inc_b", {16'd0, add_b_o}, 32'd2);
                check("inc_ci", {31'd0, add_ci_o}, 32'd0);
            end
            check("busy_run", {31'd0, busy_o}, 32'd1);
            if (c == inject_cyc) begin
                start_i = 1'b1;
                x_i     = 16'd9;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            c++;
        end
        start_i = 1'b0;
        check("done_seen", {31'd0, done_o}, 32'd1);
        check("latency", 32'(c), 32'(2 * r + 2));
        check("root", {24'd0, root_o}, 32'(r));
        check("rem", {16'd0, rem_o}, 32'(rem));
        check("busy_done", {31'd0, busy_o}, 32'd0);
        check("done_cla", {15'd0, add_ci_o, add_a_o}, 32'd0);
        @(negedge clk_i);
        check("done_pulse", {31'd0, done_o}, 32'd0);
        check("root_hold", {24'd0, root_o}, 32'(r));
        check("rem_hold", {16'd0, rem_o}, 32'(rem));
    endtask

    initial begin
        int c;
        int rr;
        rst_i   = 1'b1;
        start_i = 1'b0;
        x_i     = 16'd0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_root", {24'd0, root_o}, 32'd0);
        check("rst_rem", {16'd0, rem_o}, 32'd0);
        check("rst_cla", {15'd0, add_ci_o, add_b_o}, 32'd0);
        rst_i = 1'b0;

        // Directed boundaries and examples.
        do_op(0, 0);
        do_op(16, 0);
        do_op(15, 0);
        do_op(65535, 0);
        do_op(65025, 0);

        // Start while busy is ignored; outputs then hold in IDLE.
        do_op(100, 5);
        repeat (5) begin
            @(negedge clk_i);
            check("idle_no_done", {31'd0, done_o}, 32'd0);
            check("idle_root", {24'd0, root_o}, 32'd10);
            check("idle_rem", {16'd0, rem_o}, 32'd0);
        end

        // Reset in the middle of a long computation.
        @(negedge clk_i);
        start_i = 1'b1;
        x_i     = 16'd40000;
        @(negedge clk_i);
        start_i = 1'b0;
        c = 1;
        while (c < 50) begin
            @(negedge clk_i);
            c++;
        end
        check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_done", {31'd0, done_o}, 32'd0);
        check("mid_rst_root", {24'd0, root_o}, 32'd0);
        check("mid_rst_rem", {16'd0, rem_o}, 32'd0);
        check("mid_rst_cla", {15'd0, add_ci_o, add_a_o}, 32'd0);
        repeat (20) begin
            @(negedge clk_i);
            check("post_rst_quiet", {30'd0, done_o, busy_o}, 32'd0);
        end
        do_op(2, 0);

        // Randomized radicands and random perfect squares.
        repeat (25) do_op(int'($urandom_range(0, 65535)), 0);
        repeat (10) begin
            rr = int'($urandom_range(0, 255));
            do_op(rr * rr, 0);
        end
        repeat (10) do_op(int'($urandom_range(0, 300)), int'($urandom_range(1, 4)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sqrt_seq_ctrl.md
# sqrt_seq_ctrl

Multi-cycle integer square-root sequencer that time-shares one external 16-bit CLA adder (`A_i + B_i + Ci_i -> S_o, Co_o`). It computes `floor(sqrt(X))` and the remainder by subtracting successive odd numbers. Subtraction is formed as `A + ~B + 1`. The block is the control layer of the structural square-root unit, sitting between the host handshake and the CLA datapath.

## Interface
Parameters:
- none; widths are fixed: operand 16 bits, root 8 bits, remainder 16 bits.

Ports:
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `start_i` in 1: request; sampled only in IDLE.
- `x_i` in 16: radicand; captured on an accepted start.
- `busy_o` out 1: high in SUB and INC.
- `done_o` out 1: one-cycle pulse in DONE.
- `root_o` out 8: `floor(sqrt(X))`; registered and held until the next DONE.
- `rem_o` out 16: `X - root^2` (max 510); registered and held.
- `add_a_o` out 16: CLA operand A.
- `add_b_o` out 16: CLA operand B.
- `add_ci_o` out 1: CLA carry-in.
- `add_s_i` in 16: CLA sum.
- `add_co_i` in 1: CLA carry-out.

## Operation
- Internal registers:
  - `rem_r` (16): running remainder.
  - `odd_r` (16): current odd number; max 511.
  - `state_r`: {IDLE, SUB, INC, DONE}.
- IDLE:
  - CLA drive: `add_a_o=0`, `add_b_o=0`, `add_ci_o=0`.
  - If `start_i=1`: `rem_r<=x_i`, `odd_r<=1`, go to SUB.
- SUB:
  - CLA drive: `add_a_o=rem_r`, `add_b_o=~odd_r`, `add_ci_o=1`.
  - If `add_co_i=1` (no borrow, `rem_r>=odd_r`): `rem_r<=add_s_i`, go to INC.
  - Else: `root_o<=odd_r[8:1]`, `rem_o<=rem_r`, go to DONE.
- INC:
  - CLA drive: `add_a_o=odd_r`, `add_b_o=16'h0002`, `add_ci_o=0`.
  - `odd_r<=add_s_i`, go to SUB.
- DONE:
  - CLA drive: zeros, as in IDLE.
  - `done_o=1`; go to IDLE unconditionally.
  - `start_i` is ignored in this cycle.
- `start_i` is ignored in SUB, INC and DONE; no queuing.
- Arithmetic is done only in the external CLA; the block contains no adder or comparator of its own. The root is derived as `(odd-1)/2`, i.e. `odd_r[8:1]`.
- `add_co_i` is the sole termination criterion. The final failing subtraction never updates `rem_r`.

## Timing
- Reset (`rst_i=1` at an edge), from any state including mid-operation:
  - `state_r=IDLE`.
  - `busy_o=0`, `done_o=0`, `root_o=0`, `rem_o=0`.
  - `rem_r=0`, `odd_r=0`, CLA drive all zero.
  - Any in-flight computation is discarded; no `done_o` is produced for it.
- The CLA is combinational. Operands are driven from state registers, and the result is consumed at the end of the same cycle: one adder op per cycle.
- Start accepted in cycle 0 (IDLE, `start_i=1`):
  - SUB/INC alternate over cycles 1..2r+1: r+1 SUB cycles, r INC cycles.
  - DONE is cycle 2r+2, with `done_o=1` and `root_o`/`rem_o` already valid.
  - Latency = 2*root+2 cycles. Examples: X=0 → 2; X=65535 → 512.
- `busy_o` rises in cycle 1 and falls in the DONE cycle.
- Back-to-back use:
  - The earliest next accepted start is the cycle after DONE (IDLE).
  - `root_o`/`rem_o` keep the old values until the next DONE.
- Boundaries:
  - X=0: first SUB borrows → root 0, rem 0.
  - X=65535: `odd_r` peaks at 511, with no 16-bit overflow.
  - Perfect squares end with rem 0.

## Test plan
- Reset, then X=0 start → `done_o` pulse exactly 2 cycles after start; root 0, rem 0; `busy_o` high only in cycle 1.
- X=16 → done at +10; root 4, rem 0. X=15 → done at +8; root 3, rem 6.
- X=65535 → done at +512; root 255, rem 510. X=65025 → root 255, rem 0.
- Start X=100, then pulse `start_i` with X=9 while busy → ignored: single `done_o` with root 10, rem 0; outputs hold until next DONE.
- Start X=40000, assert `rst_i` in cycle 50 → the next cycle is IDLE with all outputs 0 and no `done_o`. A fresh start with X=2 gives root 1, rem 1 at +4.
- Exhaustive sweep X=0..65535 → root/rem match a golden model; latency = 2*root+2; CLA ops in SUB are always A + ~B + 1.
